tcbm_tpi_hs: RTL and testbench

//  Parametrised, clocked successor of the TCBM-side 6523 port emulation.
//  - Three GPIO ports (A/B/C) of configurable width with data-direction registers.
//  - A DAV/ACK byte handshake engine on port A, with a timeout counter and sticky status flags.
//  - Sits between the externally decoded TCBM select (FEC0/FEF0 window) and the drive-side connector.

---
 rtl/tcbm_tpi_hs_if.sv | 12 +
 rtl/tcbm_tpi_hs.sv | 156 +++++++++++++++
 tb/tb_tcbm_tpi_hs.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcbm_tpi_hs_if.sv
// CPU-side select/strobe signals and the DAV/ACK handshake pair of the TCBM TPI.
// Tri-state lines (data bus, GPIO pins, _irq) stay as plain module ports.
interface tcbm_tpi_hs_if;
  logic       sel;
  logic       _write;
  logic [2:0] rs;
  logic       dav;
  logic       ack;

  modport master (output sel, output _write, output rs, output ack, input dav);
  modport slave  (input sel, input _write, input rs, input ack, output dav);
endinterface

// File: rtl/tcbm_tpi_hs.sv
// TCBM-side TPI: three GPIO ports with DDRs plus a DAV/ACK handshake engine on port A.
// Optional feature macro: TPI_IRQ_EN (open-drain _irq from DONE/TOUT flags).
module tcbm_tpi_hs #(
  parameter int PA_W    = 8,
  parameter int PB_W    = 2,
  parameter int PC_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            phi2,
  input  logic            _reset,
  tcbm_tpi_hs_if.slave    bus,
  inout  wire  [7:0]      data,
  inout  wire  [PA_W-1:0] port_a,
  inout  wire  [PB_W-1:0] port_b,
  inout  wire  [PC_W-1:0] port_c,
  output wire             _irq
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {ST_IDLE = 1'b0, ST_STROBE = 1'b1} state_t;

  logic [PA_W-1:0] pra_r, ddra_r;
  logic [PB_W-1:0] prb_r, ddrb_r;
  logic [PC_W-1:0] prc_r, ddrc_r;
  logic            hs_en_r, ack_pol_r, ie_done_r, ie_to_r;
  logic            done_r, tout_r, dav_r;
  logic [CNT_W-1:0] cnt_r;
  state_t          state_r;
  logic            ack_s1_r, ack_s2_r, ack_s3_r;

  logic       wr_s, pra_wr_s, hssr_rd_s, ack_edge_s;
  logic [7:0] rd_a_s, rd_b_s, rd_c_s, rdata_s;

  // Bus decode and the combinational read mux (pins seen where DDR bit is 0).
  always_comb begin
    wr_s      = bus.sel && !bus._write;
    pra_wr_s  = wr_s && (bus.rs == 3'd0);
    hssr_rd_s = bus.sel && bus._write && (bus.rs == 3'd7);
    rd_a_s = 8'h00;
    rd_b_s = 8'h00;
    rd_c_s = 8'h00;
    rd_a_s[PA_W-1:0] = (ddra_r & pra_r) | (~ddra_r & port_a);
    rd_b_s[PB_W-1:0] = (ddrb_r & prb_r) | (~ddrb_r & port_b);
    rd_c_s[7 -: PC_W] = (ddrc_r & prc_r) | (~ddrc_r & port_c);
    case (bus.rs)
      3'd0:    rdata_s = rd_a_s;
      3'd1:    rdata_s = rd_b_s;
      3'd2:    rdata_s = rd_c_s;
      3'd3:    begin rdata_s = 8'h00; rdata_s[PA_W-1:0] = ddra_r; end
      3'd4:    begin rdata_s = 8'h00; rdata_s[PB_W-1:0] = ddrb_r; end
      3'd5:    begin rdata_s = 8'h00; rdata_s[7 -: PC_W] = ddrc_r; end
      3'd6:    rdata_s = {2'b00, ie_to_r, ie_done_r, 2'b00, ack_pol_r, hs_en_r};
      default: rdata_s = {5'b00000, tout_r, done_r, (state_r == ST_STROBE)};
    endcase
  end

  // CPU register writes on the falling phi2 edge.
  always_ff @(negedge phi2 or negedge _reset) begin
    if (!_reset) begin
      pra_r <= '0; ddra_r <= '0;
      prb_r <= '0; ddrb_r <= '0;
      prc_r <= '0; ddrc_r <= '0;
      hs_en_r <= 1'b0; ack_pol_r <= 1'b0; ie_done_r <= 1'b0; ie_to_r <= 1'b0;
    end else if (wr_s) begin
      case (bus.rs)
        3'd0: pra_r  <= data[PA_W-1:0];
        3'd1: prb_r  <= data[PB_W-1:0];
        3'd2: prc_r  <= data[7 -: PC_W];
        3'd3: ddra_r <= data[PA_W-1:0];
        3'd4: ddrb_r <= data[PB_W-1:0];
        3'd5: ddrc_r <= data[7 -: PC_W];
        3'd6: begin
          hs_en_r   <= data[0];
          ack_pol_r <= data[1];
          ie_done_r <= data[4];
          ie_to_r   <= data[5];
        end
        default: begin end
      endcase
    end
  end

  // Two-flop synchroniser for ack plus a third stage for edge detection.
  always_ff @(negedge phi2 or negedge _reset) begin
    if (!_reset) begin
      ack_s1_r <= 1'b0; ack_s2_r <= 1'b0; ack_s3_r <= 1'b0;
    end else begin
      ack_s1_r <= bus.ack; ack_s2_r <= ack_s1_r; ack_s3_r <= ack_s2_r;
    end
  end

  assign ack_edge_s = ack_pol_r ? (ack_s2_r & ~ack_s3_r) : (~ack_s2_r & ack_s3_r);

  // Handshake FSM, timeout counter and sticky flags; a flag set beats a same-edge read clear.
  always_ff @(negedge phi2 or negedge _reset) begin
    if (!_reset) begin
      state_r <= ST_IDLE; dav_r <= 1'b1; cnt_r <= '0;
      done_r  <= 1'b0;    tout_r <= 1'b0;
    end else begin
      if (hssr_rd_s) begin
        done_r <= 1'b0;
        tout_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (pra_wr_s && hs_en_r) begin
            state_r <= ST_STROBE; dav_r <= 1'b0; cnt_r <= '0;
          end else begin
            dav_r <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (!hs_en_r) begin
            state_r <= ST_IDLE; dav_r <= 1'b1;
          end else if (pra_wr_s) begin
            cnt_r <= '0;
          end else if (ack_edge_s) begin
            state_r <= ST_IDLE; dav_r <= 1'b1; done_r <= 1'b1;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            state_r <= ST_IDLE; dav_r <= 1'b1; tout_r <= 1'b1;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE; dav_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dav = dav_r;
  assign data    = (bus.sel && bus._write) ? rdata_s : 8'hzz;

  for (genvar i = 0; i < PA_W; i++) begin : g_pa
    assign port_a[i] = ddra_r[i] ? pra_r[i] : 1'bz;
  end
  for (genvar i = 0; i < PB_W; i++) begin : g_pb
    assign port_b[i] = ddrb_r[i] ? prb_r[i] : 1'bz;
  end
  for (genvar i = 0; i < PC_W; i++) begin : g_pc
    assign port_c[i] = ddrc_r[i] ? prc_r[i] : 1'bz;
  end

`ifdef TPI_IRQ_EN
  logic irq_act_s;
  assign irq_act_s = (done_r && ie_done_r) || (tout_r && ie_to_r);
  assign _irq = irq_act_s ? 1'b0 : 1'bz;
`else
  assign _irq = 1'bz;
`endif

endmodule

// File: tb/tb_tcbm_tpi_hs.sv
// Scoreboard bench for tcbm_tpi_hs (TIMEOUT=4): register reads are queued and compared.
module tb_tcbm_tpi_hs;
  logic phi2 = 1'b1;
  logic _reset;
  always #5 phi2 = ~phi2;

  tcbm_tpi_hs_if bus_if();
  wire [7:0] data;
  wire [7:0] port_a;
  wire [1:0] port_b;
  wire [1:0] port_c;
  wire       irq_n;
  pullup (irq_n);

  logic [7:0] d_drv;
  logic       d_en;
  logic [7:0] pa_en, pa_val;
  logic [1:0] pb_en, pb_val, pc_en, pc_val;

  assign data = d_en ? d_drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pa
    assign port_a[i] = pa_en[i] ? pa_val[i] : 1'bz;
  end
  for (genvar i = 0; i < 2; i++) begin : g_pbc
    assign port_b[i] = pb_en[i] ? pb_val[i] : 1'bz;
    assign port_c[i] = pc_en[i] ? pc_val[i] : 1'bz;
  end

  tcbm_tpi_hs #(.PA_W(8), .PB_W(2), .PC_W(2), .TIMEOUT(4)) dut (
    .phi2   (phi2),
    ._reset (_reset),
    .bus    (bus_if),
    .data   (data),
    .port_a (port_a),
    .port_b (port_b),
    .port_c (port_c),
    ._irq   (irq_n)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%02h exp=%02h", tag, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge phi2);
    bus_if.sel = 1'b1; bus_if._write = 1'b0; bus_if.rs = a; d_drv = d; d_en = 1'b1;
    @(negedge phi2);
    #1;
    bus_if.sel = 1'b0; bus_if._write = 1'b1; d_en = 1'b0;
  endtask

  task automatic cpu_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge phi2);
    bus_if.sel = 1'b1; bus_if._write = 1'b1; bus_if.rs = a;
    #2 got = data;
    @(negedge phi2);
    #1;
    bus_if.sel = 1'b0;
    check_val(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge phi2);
    #1;
  endtask

  initial begin
    bus_if.sel = 1'b0; bus_if._write = 1'b1; bus_if.rs = 3'd0; bus_if.ack = 1'b1;
    d_en = 1'b0; d_drv = 8'h00;
    pa_en = 8'hFF; pa_val = 8'hFF; pb_en = 2'b11; pb_val = 2'b11; pc_en = 2'b11; pc_val = 2'b11;
    _reset = 1'b0;
    repeat (3) @(posedge phi2);
    #1 check_val("rst_dav_held", {7'h0, bus_if.dav}, 8'h01);
    #1 _reset = 1'b1;
    edges(3);

    // Reset values with all pins pulled high.
    check_val("rst_dav", {7'h0, bus_if.dav}, 8'h01);
    check_val("rst_irq", {7'h0, irq_n}, 8'h01);
    cpu_rd("rst_pra", 3'd0, 8'hFF);
    cpu_rd("rst_prb", 3'd1, 8'h03);
    cpu_rd("rst_prc", 3'd2, 8'hC0);
    cpu_rd("rst_ddra", 3'd3, 8'h00);
    cpu_rd("rst_ddrb", 3'd4, 8'h00);
    cpu_rd("rst_ddrc", 3'd5, 8'h00);
    cpu_rd("rst_hscr", 3'd6, 8'h00);
    cpu_rd("rst_hssr", 3'd7, 8'h00);

    // GPIO direction mixing on A, B and C.
    pa_en = 8'hF0; pa_val = 8'hC0;
    cpu_wr(3'd3, 8'h0F);
    cpu_wr(3'd0, 8'hA5);
    check_val("pa_pins", port_a, 8'hC5);
    cpu_rd("pa_read", 3'd0, 8'hC5);
    pb_en = 2'b10; pb_val = 2'b10;
    cpu_wr(3'd4, 8'h01);
    cpu_wr(3'd1, 8'h00);
    check_val("pb_pins", {6'h0, port_b}, 8'h02);
    cpu_rd("pb_read", 3'd1, 8'h02);
    pc_en = 2'b01; pc_val = 2'b01;
    cpu_wr(3'd5, 8'h80);
    cpu_wr(3'd2, 8'h00);
    check_val("pc_pins", {6'h0, port_c}, 8'h01);
    cpu_rd("pc_read", 3'd2, 8'h40);
    cpu_rd("ddrc_read", 3'd5, 8'h80);
    cpu_wr(3'd7, 8'hFF);
    cpu_rd("hssr_wr_ignored", 3'd7, 8'h00);

    // Handshake completed by ack; DONE set on the same edge as a HSSR read.
    cpu_wr(3'd6, 8'h01);
    cpu_wr(3'd0, 8'h3C);
    bus_if.ack = 1'b0;
    check_val("hs_dav_e0", {7'h0, bus_if.dav}, 8'h00);
    cpu_rd("hs_busy", 3'd7, 8'h01);
    edges(1);
    check_val("hs_dav_e2", {7'h0, bus_if.dav}, 8'h00);
    cpu_rd("hs_set_vs_clr", 3'd7, 8'h01);
    check_val("hs_dav_e3", {7'h0, bus_if.dav}, 8'h01);
    cpu_rd("hs_done", 3'd7, 8'h02);
    cpu_rd("hs_clr", 3'd7, 8'h00);
    bus_if.ack = 1'b1;
    edges(3);

    // Timeout: dav low for exactly 4 cycles.
    cpu_wr(3'd0, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      edges(1);
      check_val($sformatf("to_dav_e%0d", k), {7'h0, bus_if.dav}, (k == 4) ? 8'h01 : 8'h00);
    end
    cpu_rd("to_flag", 3'd7, 8'h04);
    cpu_rd("to_clr", 3'd7, 8'h00);

    // Ack edge lands on the timeout cycle: ack wins.
    cpu_wr(3'd0, 8'h11);
    edges(1);
    bus_if.ack = 1'b0;
    edges(2);
    check_val("race_dav_e3", {7'h0, bus_if.dav}, 8'h00);
    edges(1);
    check_val("race_dav_e4", {7'h0, bus_if.dav}, 8'h01);
    cpu_rd("race_ack_wins", 3'd7, 8'h02);
    bus_if.ack = 1'b1;
    edges(3);

    // PRA rewrite mid-STROBE restarts the counter.
    cpu_wr(3'd0, 8'h22);
    edges(2);
    cpu_wr(3'd0, 8'h33);
    for (int k = 4; k <= 7; k++) begin
      edges(1);
      check_val($sformatf("restart_dav_e%0d", k), {7'h0, bus_if.dav}, (k == 7) ? 8'h01 : 8'h00);
    end
    cpu_rd("restart_flag", 3'd7, 8'h04);
    cpu_rd("restart_pra", 3'd0, 8'hC3);

    // HS_EN cleared mid-STROBE aborts without flags.
    cpu_wr(3'd0, 8'h44);
    cpu_wr(3'd6, 8'h00);
    check_val("abort_dav_e1", {7'h0, bus_if.dav}, 8'h00);
    edges(1);
    check_val("abort_dav_e2", {7'h0, bus_if.dav}, 8'h01);
    cpu_rd("abort_flags", 3'd7, 8'h00);

    // Ack edge while idle is ignored.
    cpu_wr(3'd6, 8'h01);
    bus_if.ack = 1'b0;
    edges(4);
    bus_if.ack = 1'b1;
    edges(4);
    check_val("idle_ack_dav", {7'h0, bus_if.dav}, 8'h01);
    cpu_rd("idle_ack_flags", 3'd7, 8'h00);

    // Rising-edge ack polarity.
    cpu_wr(3'd6, 8'h03);
    bus_if.ack = 1'b0;
    edges(3);
    cpu_wr(3'd0, 8'h55);
    bus_if.ack = 1'b1;
    edges(2);
    check_val("pol_dav_e2", {7'h0, bus_if.dav}, 8'h00);
    edges(1);
    check_val("pol_dav_e3", {7'h0, bus_if.dav}, 8'h01);
    cpu_rd("pol_done", 3'd7, 8'h02);

    // IRQ on DONE with IE_DONE set.
    cpu_wr(3'd6, 8'h11);
    cpu_wr(3'd0, 8'h66);
    bus_if.ack = 1'b0;
    edges(3);
    check_val("irq_dav", {7'h0, bus_if.dav}, 8'h01);
`ifdef TPI_IRQ_EN
    check_val("irq_asserted", {7'h0, irq_n}, 8'h00);
`else
    check_val("irq_inactive", {7'h0, irq_n}, 8'h01);
`endif
    cpu_rd("irq_hssr", 3'd7, 8'h02);
    check_val("irq_released", {7'h0, irq_n}, 8'h01);
    bus_if.ack = 1'b1;
    edges(3);

    // Reset pulse mid-STROBE with TOUT already pending.
    cpu_wr(3'd6, 8'h01);
    cpu_wr(3'd0, 8'h77);
    edges(4);
    cpu_wr(3'd0, 8'h78);
    edges(1);
    @(posedge phi2);
    #2 _reset = 1'b0;
    pa_en = 8'hFF; pa_val = 8'hFF; pb_en = 2'b11; pb_val = 2'b11; pc_en = 2'b11; pc_val = 2'b11;
    #1 check_val("rst2_dav", {7'h0, bus_if.dav}, 8'h01);
    @(posedge phi2);
    #2 _reset = 1'b1;
    cpu_rd("rst2_hssr", 3'd7, 8'h00);
    cpu_rd("rst2_hscr", 3'd6, 8'h00);
    cpu_rd("rst2_pra", 3'd0, 8'hFF);

    check_val("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
